weight2_seq_ctrl: RTL
=====================

// Module: weight2_seq_ctrl
// PURPOSE
//   Sequencer for the layer-2 weight bank (9 rows x 5 outputs, signed 16-bit).
//   Drives the bank's row index and write enable for two operations: a forward
//   read sweep of rows 0..N_ROWS-1, and a backward update sweep in which each
//   row accumulates its delta. Also owns the training step counter; the bank
//   ignores updates while step==0. Sits between the DQN top-level FSM and the
//   weight bank.
// PARAMETERS
//   N_ROWS       9   rows per sweep (hidden units incl. bias)
//   ROW_W        4   width of row_idx; 2**ROW_W must be >= N_ROWS
//   STEP_W       4   width of the step counter
//   SYNC_PERIOD  8   update passes between target-sync pulses (TGT_SYNC_EN only)
// PORTS
//   clk        in   1       clock, all state updates on the rising edge
//   rst_n      in   1       synchronous reset, active-low
//   fwd_start  in   1       one-cycle request for a forward read sweep
//   bwd_start  in   1       one-cycle request for an update sweep (deltas valid)
//   row_idx    out  ROW_W   row address to the weight bank (its st input)
//   row_vld    out  1       row_idx is a valid forward-read row this cycle
//   upd_en     out  1       bank adds delta to row row_idx on this edge
//   step       out  STEP_W  training step counter (bank step input)
//   busy       out  1       state != IDLE
//   fwd_done   out  1       one-cycle pulse: forward sweep complete
//   bwd_done   out  1       one-cycle pulse: update sweep complete
//   tgt_sync   out  1       one-cycle pulse: copy online -> target net
// BEHAVIOUR
//   - Reset (rst_n==0 at an edge): state=IDLE, row_idx=0, step=0, pending=0,
//     sync_cnt=0. All outputs 0. Takes priority over everything, including an
//     in-progress sweep, which is abandoned with no done pulse.
//   - FSM states: IDLE, FWD, BWD. All outputs are registered.
//   - IDLE:
//     - fwd_start=1 -> FWD.
//     - else (bwd_start | pending) -> BWD, and pending clears.
//     - If fwd_start and bwd_start are both 1, FWD is taken and pending is set.
//   - FWD: row_vld=1, row_idx = 0,1,..,N_ROWS-1 on consecutive cycles.
//     - Request edge at T: row 0 appears at T+1, row N_ROWS-1 at T+N_ROWS.
//     - At T+N_ROWS+1: fwd_done=1, row_vld=0, row_idx=0, state=IDLE.
//   - BWD: upd_en=1, row_idx sweeps 0..N_ROWS-1 with the same timing as FWD.
//     - After the last row: bwd_done=1, upd_en=0, state=IDLE, step increments.
//   - Step counter: wraps from 2**STEP_W-1 to 1, never back to 0, so updates
//     are never gated after the first pass. The first pass after reset runs
//     with step==0; the bank ignores those writes by design.
//   - In FWD or BWD: fwd_start is ignored. bwd_start sets pending, which is one
//     deep; extra requests are dropped.
//   - Pending service: the done cycle is an IDLE cycle. If pending is set,
//     BWD starts on the next edge with no extra gap.
//   - row_vld and upd_en are never 1 in the same cycle. row_idx never reaches
//     N_ROWS or above.
// CONFIGURATION
//   - Macro WEIGHT2_TGT_SYNC_EN defined:
//     - A counter sync_cnt (width $clog2(SYNC_PERIOD+1)) increments on each
//       bwd_done.
//     - When the increment reaches SYNC_PERIOD, tgt_sync pulses in the same
//       cycle as bwd_done and sync_cnt returns to 0.
//     - Reset clears sync_cnt.
//   - Macro undefined: tgt_sync is tied to 0 and there is no counter logic.
// TESTING
//   1 Reset: hold rst_n=0 for 3 edges mid-BWD -> all outputs 0 next cycle,
//     step=0, and no bwd_done pulse.
//   2 fwd_start pulse at T -> row_vld=1 with row_idx 0..8 at T+1..T+9;
//     fwd_done=1 at T+10 only; busy high T+1..T+9.
//   3 bwd_start pulse -> upd_en=1 for exactly 9 cycles over rows 0..8;
//     bwd_done one cycle later; step goes 0 -> 1.
//   4 fwd_start and bwd_start in the same cycle, plus a 2nd bwd_start during
//     FWD -> exactly one BWD sweep starts the cycle after fwd_done; step +1.
//   5 Run 16 back-to-back update passes from reset -> step reads
//     1,2,..,15,1; it never returns to 0.
//   6 (WEIGHT2_TGT_SYNC_EN) 17 update passes -> tgt_sync coincides with the
//     8th and 16th bwd_done only. Without the macro, tgt_sync stays 0.

Source files
------------

// File: rtl/weight2_seq_ctrl_if.sv
// Request/response bundle between the DQN top-level FSM (master) and the
// layer-2 weight sequencer (slave).
interface weight2_seq_ctrl_if #(
    parameter int unsigned ROW_W  = 4,
    parameter int unsigned STEP_W = 4
);
    logic              fwd_start;
    logic              bwd_start;
    logic [ROW_W-1:0]  row_idx;
    logic              row_vld;
    logic              upd_en;
    logic [STEP_W-1:0] step;
    logic              busy;
    logic              fwd_done;
    logic              bwd_done;
    logic              tgt_sync;

    modport master (
        output fwd_start, bwd_start,
        input  row_idx, row_vld, upd_en, step, busy, fwd_done, bwd_done, tgt_sync
    );

    modport slave (
        input  fwd_start, bwd_start,
        output row_idx, row_vld, upd_en, step, busy, fwd_done, bwd_done, tgt_sync
    );
endinterface

// File: rtl/weight2_seq_ctrl.sv
// Layer-2 weight bank sequencer: forward read sweep, backward update sweep and
// training step counter. Define WEIGHT2_TGT_SYNC_EN to enable target-sync pulses.
module weight2_seq_ctrl #(
    parameter int unsigned N_ROWS      = 9,
    parameter int unsigned ROW_W       = 4,
    parameter int unsigned STEP_W      = 4,
    parameter int unsigned SYNC_PERIOD = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    weight2_seq_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_BWD} state_e;

    localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(N_ROWS - 1);
    localparam logic [STEP_W-1:0] STEP_MAX = '1;

    if (((1 << ROW_W) < N_ROWS) || (SYNC_PERIOD < 1)) begin : g_bad_cfg
        $error("weight2_seq_ctrl: invalid parameter set");
    end

    state_e            state_q,    state_d;
    logic [ROW_W-1:0]  row_idx_q,  row_idx_d;
    logic              row_vld_q,  row_vld_d;
    logic              upd_en_q,   upd_en_d;
    logic [STEP_W-1:0] step_q,     step_d;
    logic              busy_q,     busy_d;
    logic              fwd_done_q, fwd_done_d;
    logic              bwd_done_q, bwd_done_d;
    logic              pending_q,  pending_d;
    logic              tgt_sync_d;

`ifdef WEIGHT2_TGT_SYNC_EN
    localparam int unsigned SYNC_W = $clog2(SYNC_PERIOD + 1);
    logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
    logic              tgt_sync_q;
`endif

    always_comb begin
        state_d    = state_q;
        row_idx_d  = row_idx_q;
        row_vld_d  = row_vld_q;
        upd_en_d   = upd_en_q;
        step_d     = step_q;
        busy_d     = busy_q;
        pending_d  = pending_q;
        fwd_done_d = 1'b0;
        bwd_done_d = 1'b0;
        tgt_sync_d = 1'b0;
`ifdef WEIGHT2_TGT_SYNC_EN
        sync_cnt_d = sync_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // A simultaneous fwd/bwd request runs forward first; the update is queued.
                if (bus.fwd_start) begin
                    state_d   = ST_FWD;
                    row_idx_d = '0;
                    row_vld_d = 1'b1;
                    busy_d    = 1'b1;
                    pending_d = bus.bwd_start;
                end else if (bus.bwd_start || pending_q) begin
                    state_d   = ST_BWD;
                    row_idx_d = '0;
                    upd_en_d  = 1'b1;
                    busy_d    = 1'b1;
                    pending_d = 1'b0;
                end
            end
            ST_FWD: begin
                pending_d = pending_q | bus.bwd_start;
                if (row_idx_q == LAST_ROW) begin
                    state_d    = ST_IDLE;
                    row_idx_d  = '0;
                    row_vld_d  = 1'b0;
                    busy_d     = 1'b0;
                    fwd_done_d = 1'b1;
                end else begin
                    row_idx_d = row_idx_q + ROW_W'(1);
                end
            end
            ST_BWD: begin
                pending_d = pending_q | bus.bwd_start;
                if (row_idx_q == LAST_ROW) begin
                    state_d    = ST_IDLE;
                    row_idx_d  = '0;
                    upd_en_d   = 1'b0;
                    busy_d     = 1'b0;
                    bwd_done_d = 1'b1;
                    // Step skips 0 on wrap so the bank never gates updates again.
                    step_d     = (step_q == STEP_MAX) ? STEP_W'(1) : step_q + STEP_W'(1);
`ifdef WEIGHT2_TGT_SYNC_EN
                    if (sync_cnt_q == SYNC_W'(SYNC_PERIOD - 1)) begin
                        sync_cnt_d = '0;
                        tgt_sync_d = 1'b1;
                    end else begin
                        sync_cnt_d = sync_cnt_q + SYNC_W'(1);
                    end
`endif
                end else begin
                    row_idx_d = row_idx_q + ROW_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                row_idx_d = '0;
                row_vld_d = 1'b0;
                upd_en_d  = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            row_idx_q  <= '0;
            row_vld_q  <= 1'b0;
            upd_en_q   <= 1'b0;
            step_q     <= '0;
            busy_q     <= 1'b0;
            fwd_done_q <= 1'b0;
            bwd_done_q <= 1'b0;
            pending_q  <= 1'b0;
`ifdef WEIGHT2_TGT_SYNC_EN
            sync_cnt_q <= '0;
            tgt_sync_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            row_idx_q  <= row_idx_d;
            row_vld_q  <= row_vld_d;
            upd_en_q   <= upd_en_d;
            step_q     <= step_d;
            busy_q     <= busy_d;
            fwd_done_q <= fwd_done_d;
            bwd_done_q <= bwd_done_d;
            pending_q  <= pending_d;
`ifdef WEIGHT2_TGT_SYNC_EN
            sync_cnt_q <= sync_cnt_d;
            tgt_sync_q <= tgt_sync_d;
`endif
        end
    end

    assign bus.row_idx  = row_idx_q;
    assign bus.row_vld  = row_vld_q;
    assign bus.upd_en   = upd_en_q;
    assign bus.step     = step_q;
    assign bus.busy     = busy_q;
    assign bus.fwd_done = fwd_done_q;
    assign bus.bwd_done = bwd_done_q;
`ifdef WEIGHT2_TGT_SYNC_EN
    assign bus.tgt_sync = tgt_sync_q;
`else
    assign bus.tgt_sync = 1'b0;
    logic unused_tgt_sync;
    assign unused_tgt_sync = tgt_sync_d;
`endif
endmodule
